// File: rtl/signed_div_seq.sv
// Iterative restoring divider, one quotient bit per cycle, signed/unsigned.
// Optional SIGNED_DIV_DIV0_FAST_EN: zero divisor skips straight to DONE.
module signed_div_seq #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [A_WIDTH-1:0] dat_a,
  input  logic [B_WIDTH-1:0] dat_b,
  input  logic               tc,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [A_WIDTH-1:0] quotient,
  output logic [B_WIDTH-1:0] remainder,
  output logic               div_zero,
  output logic               busy
);

  localparam int CW = (A_WIDTH > 1) ? $clog2(A_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state;

  logic [CW-1:0]      cnt;
  logic               tc_r;
  logic               sign_a;
  logic               sign_b;
  logic               zero_r;
  logic [A_WIDTH-1:0] mag_a;
  logic [A_WIDTH-1:0] quo;
  logic [B_WIDTH-1:0] mag_b;
  logic [B_WIDTH:0]   prem;

  logic               neg_a;
  logic               neg_b;
  logic [A_WIDTH-1:0] abs_a;
  logic [B_WIDTH-1:0] abs_b;
  logic [B_WIDTH:0]   shifted;
  logic [B_WIDTH+1:0] trial;
  logic               q_bit;

  assign neg_a = tc & dat_a[A_WIDTH-1];
  assign neg_b = tc & dat_b[B_WIDTH-1];
  assign abs_a = neg_a ? -dat_a : dat_a;
  assign abs_b = neg_b ? -dat_b : dat_b;

  // Extra top bit of trial acts as the borrow / sign of the subtraction
  assign shifted = {prem[B_WIDTH-1:0], mag_a[A_WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, mag_b};
  assign q_bit   = ~trial[B_WIDTH+1];

  assign in_rdy  = (state == IDLE);
  assign busy    = (state != IDLE);
  assign out_vld = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tc_r      <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      zero_r    <= 1'b0;
      mag_a     <= '0;
      mag_b     <= '0;
      quo       <= '0;
      prem      <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_vld) begin
            tc_r   <= tc;
            sign_a <= dat_a[A_WIDTH-1];
            sign_b <= dat_b[B_WIDTH-1];
            zero_r <= (dat_b == '0);
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            quo    <= '0;
            prem   <= '0;
            cnt    <= CW'(A_WIDTH - 1);
`ifdef SIGNED_DIV_DIV0_FAST_EN
            if (dat_b == '0) begin
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          mag_a <= mag_a << 1;
          prem  <= q_bit ? trial[B_WIDTH:0] : shifted;
          quo   <= {quo[A_WIDTH-2:0], q_bit};
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zero_r) begin
            quotient  <= '1;
            remainder <= '0;
            div_zero  <= 1'b1;
          end else begin
            quotient  <= (tc_r & (sign_a ^ sign_b)) ? -quo : quo;
            remainder <= (tc_r & sign_a) ? -prem[B_WIDTH-1:0]
                                         : prem[B_WIDTH-1:0];
            div_zero  <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          if (out_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
